// File: rtl/recv_contest_out.sv
// 8N1 UART receiver (LSB first, idle high) feeding a circular capture FIFO with sticky error flags.
// Optional macro RECV_IDLE_TIMEOUT_EN adds the idle_timeout output used to detect end of output.
module recv_contest_out #(
  parameter int CLK_PER_HALF_BIT = 435,
  parameter int DEPTH_LOG2       = 10,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  byte_done,
  output logic                  frame_err,
  output logic                  overflow
`ifdef RECV_IDLE_TIMEOUT_EN
  ,
  output logic                  idle_timeout
`endif
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int DEPTH    = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]         T_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]         T_ONE     = CW'(1);
  localparam logic [CW-1:0]         T_HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0]         T_FULL_M1 = CW'(BIT_CLKS - 1);
  localparam logic [DEPTH_LOG2-1:0] P_ZERO    = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] P_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   C_ZERO    = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   C_ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   C_DEPTH   = (DEPTH_LOG2+1)'(DEPTH);

  if (CLK_PER_HALF_BIT < 2 || DEPTH_LOG2 < 1 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("recv_contest_out: invalid parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_sync2, w_rxd_s;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic [7:0]            r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count, w_count_next;
  logic                  r_empty, r_full;
  logic [7:0]            r_rd_data;
  logic                  r_byte_done, r_frame_err, r_overflow;
  logic                  w_start_ok, w_sample_bit, w_stop_good, w_stop_bad;
  logic                  w_pop, w_push, w_drop;

  assign w_rxd_s = r_sync2;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Framing state machine: next state and single-cycle event strobes
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_sample_bit = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) w_state_next = S_START;
        else          w_state_next = S_IDLE;
      end
      S_START: begin
        if (r_cnt == T_HALF_M1) begin
          if (!w_rxd_s) begin
            w_state_next = S_DATA;
            w_start_ok   = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == T_FULL_M1) begin
          w_sample_bit = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
          else                   w_state_next = S_DATA;
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_STOP: begin
        if (r_cnt == T_FULL_M1) begin
          if (w_rxd_s) begin
            w_stop_good  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = S_BREAK;
          end
        end else begin
          w_state_next = S_STOP;
        end
      end
      S_BREAK: begin
        if (w_rxd_s) w_state_next = S_IDLE;
        else         w_state_next = S_BREAK;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO handshake: a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    w_pop  = rd_en & ~r_empty;
    w_push = w_stop_good & (~r_full | w_pop);
    w_drop = w_stop_good & r_full & ~w_pop;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_ONE;
      2'b01:   w_count_next = r_count - C_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // State register and bit timer; the timer restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= T_ZERO;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state)  r_cnt <= T_ZERO;
      else if (r_state == S_IDLE)   r_cnt <= T_ZERO;
      else if (r_cnt == T_FULL_M1)  r_cnt <= T_ZERO;
      else                          r_cnt <= r_cnt + T_ONE;
    end
  end

  // Deserializer: LSB arrives first, so bits enter at the MSB and shift right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_start_ok) begin
      r_bit_idx <= 3'd0;
    end else if (w_sample_bit) begin
      r_bit_idx <= r_bit_idx + 3'd1;
      r_shift   <= {w_rxd_s, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers, occupancy, registered status and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= P_ZERO;
      r_rd_ptr  <= P_ZERO;
      r_count   <= C_ZERO;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + P_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == C_ZERO);
      r_full  <= (w_count_next == C_DEPTH);
    end
  end

  // Accept pulse and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_byte_done <= w_push;
      if (w_stop_bad) r_frame_err <= 1'b1;
      if (w_drop)     r_overflow  <= 1'b1;
    end
  end

  assign rd_data   = r_rd_data;
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign byte_done = r_byte_done;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

`ifdef RECV_IDLE_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * BIT_CLKS;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TO_CLKS);

  logic          r_seen_byte, r_idle_timeout;
  logic [TW-1:0] r_idle_cnt;

  // Idle-line watchdog, armed once any byte has been accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen_byte    <= 1'b0;
      r_idle_cnt     <= TO_ZERO;
      r_idle_timeout <= 1'b0;
    end else begin
      if (w_push) r_seen_byte <= 1'b1;
      if (r_state != S_IDLE)       r_idle_cnt <= TO_ZERO;
      else if (r_idle_cnt != TO_MAX) r_idle_cnt <= r_idle_cnt + TO_ONE;
      if (w_start_ok)
        r_idle_timeout <= 1'b0;
      else if (r_state == S_IDLE && r_seen_byte && r_idle_cnt == TO_MAX)
        r_idle_timeout <= 1'b1;
    end
  end

  assign idle_timeout = r_idle_timeout;
`endif

endmodule

// File: tb/tb_recv_contest_out.sv
// Self-checking bench for recv_contest_out: a deep instance (A) and a 4-entry instance (B),
// both with an 8-clock bit, checked against a queue-based model of the byte stream.
module tb_recv_contest_out;
  logic        clk = 1'b0;
  logic        rst;
  logic        rxd_a, rd_en_a, rxd_b, rd_en_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        empty_a, full_a, done_a, ferr_a, ovf_a;
  logic        empty_b, full_b, done_b, ferr_b, ovf_b;
  logic [10:0] count_a;
  logic [2:0]  count_b;
`ifdef RECV_IDLE_TIMEOUT_EN
  logic        tmo_a, tmo_b;
`endif

  recv_contest_out #(.CLK_PER_HALF_BIT(4), .DEPTH_LOG2(10), .TIMEOUT_BITS(20)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .empty(empty_a), .full(full_a), .count(count_a), .byte_done(done_a),
    .frame_err(ferr_a), .overflow(ovf_a)
`ifdef RECV_IDLE_TIMEOUT_EN
    , .idle_timeout(tmo_a)
`endif
  );

  recv_contest_out #(.CLK_PER_HALF_BIT(4), .DEPTH_LOG2(2), .TIMEOUT_BITS(20)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .empty(empty_b), .full(full_b), .count(count_b), .byte_done(done_b),
    .frame_err(ferr_b), .overflow(ovf_b)
`ifdef RECV_IDLE_TIMEOUT_EN
    , .idle_timeout(tmo_b)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic       sel = 1'b0;
  logic [7:0] mq[$];
  int         mdepth = 1024;
  logic       exp_ferr, exp_ovf;
  logic [7:0] exp_last;

  logic       obs_done, obs_empty, obs_full, obs_ferr, obs_ovf;
  logic [7:0] obs_rd;
  int         obs_count;

  always_comb begin
    if (sel) begin
      obs_done = done_b; obs_empty = empty_b; obs_full = full_b;
      obs_ferr = ferr_b; obs_ovf = ovf_b; obs_rd = rd_data_b; obs_count = int'(count_b);
    end else begin
      obs_done = done_a; obs_empty = empty_a; obs_full = full_a;
      obs_ferr = ferr_a; obs_ovf = ovf_a; obs_rd = rd_data_a; obs_count = int'(count_a);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rxd(input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic set_rd_en(input logic v);
    if (sel) rd_en_b = v;
    else     rd_en_a = v;
  endtask

  task automatic apply_reset(input logic new_sel);
    rst = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1; rd_en_a = 1'b0; rd_en_b = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    sel = new_sel;
    mdepth = new_sel ? 4 : 1024;
    mq.delete();
    exp_ferr = 1'b0; exp_ovf = 1'b0; exp_last = 8'h00;
    tick();
  endtask

  // One 10-bit frame; optional pop aligned with the stop-bit sample cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit pop_at_stop);
    logic [9:0] bits;
    logic       exp_push;
    int         idx;
    bits = {stop_v, b, 1'b0};
    exp_push = 1'b0;
    if (pop_at_stop && mq.size() > 0) exp_last = mq.pop_front();
    if (stop_v) begin
      if (mq.size() < mdepth) begin
        mq.push_back(b);
        exp_push = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_ferr = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      set_rxd(bits[i]);
      for (int c = 0; c < 8; c++) begin
        tick();
        idx = i * 8 + c + 1;
        if (pop_at_stop && idx == 78) set_rd_en(1'b1);
        else if (pop_at_stop && idx == 79) set_rd_en(1'b0);
        n_vec++;
        if (obs_done !== ((idx == 79) && exp_push)) begin
          n_err++;
          $display("FAIL byte_done byte=%02h cycle=%0d got %b exp %b", b, idx, obs_done, (idx == 79) && exp_push);
        end
      end
    end
    n_vec++;
    if (obs_count !== mq.size() || obs_empty !== (mq.size() == 0) || obs_full !== (mq.size() == mdepth)) begin
      n_err++;
      $display("FAIL frame_status byte=%02h got count=%0d empty=%b full=%b exp count=%0d", b, obs_count, obs_empty, obs_full, mq.size());
    end
    n_vec++;
    if (obs_ferr !== exp_ferr || obs_ovf !== exp_ovf || obs_rd !== exp_last) begin
      n_err++;
      $display("FAIL frame_flags byte=%02h got ferr=%b ovf=%b rd=%02h exp ferr=%b ovf=%b rd=%02h",
               b, obs_ferr, obs_ovf, obs_rd, exp_ferr, exp_ovf, exp_last);
    end
  endtask

  task automatic pop_one();
    if (mq.size() > 0) exp_last = mq.pop_front();
    set_rd_en(1'b1);
    tick();
    set_rd_en(1'b0);
    n_vec++;
    if (obs_rd !== exp_last || obs_count !== mq.size() || obs_empty !== (mq.size() == 0)) begin
      n_err++;
      $display("FAIL pop got rd=%02h count=%0d empty=%b exp rd=%02h count=%0d", obs_rd, obs_count, obs_empty, exp_last, mq.size());
    end
  endtask

  task automatic idle(input int n);
    set_rxd(1'b1);
    for (int i = 0; i < n; i++) begin
      tick();
      n_vec++;
      if (obs_done !== 1'b0) begin
        n_err++;
        $display("FAIL idle_done got %b exp 0", obs_done);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_vec++;
    if (rd_data_a !== 8'h00 || empty_a !== 1'b1 || full_a !== 1'b0 || count_a !== 11'd0 ||
        done_a !== 1'b0 || ferr_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a got rd=%02h e=%b f=%b c=%0d d=%b fe=%b ov=%b exp 00 1 0 0 0 0 0",
               rd_data_a, empty_a, full_a, count_a, done_a, ferr_a, ovf_a);
    end
    n_vec++;
    if (rd_data_b !== 8'h00 || empty_b !== 1'b1 || full_b !== 1'b0 || count_b !== 3'd0 ||
        done_b !== 1'b0 || ferr_b !== 1'b0 || ovf_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b got rd=%02h e=%b f=%b c=%0d d=%b fe=%b ov=%b exp 00 1 0 0 0 0 0",
               rd_data_b, empty_b, full_b, count_b, done_b, ferr_b, ovf_b);
    end
  endtask

  task automatic test_single();
    idle(5);
    send_frame(8'h55, 1'b1, 1'b0);
    pop_one();
    n_vec++;
    if (rd_data_a !== 8'h55 || empty_a !== 1'b1) begin
      n_err++;
      $display("FAIL single got rd=%02h empty=%b exp 55 1", rd_data_a, empty_a);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3);
    repeat (3) pop_one();
    n_vec++;
    if (rd_data_a !== 8'hA5 || ferr_a !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back got rd=%02h ferr=%b exp a5 0", rd_data_a, ferr_a);
    end
  endtask

  task automatic test_glitch();
    set_rxd(1'b0);
    tick(); tick();
    idle(30);
    n_vec++;
    if (count_a !== 11'd0 || empty_a !== 1'b1 || ferr_a !== 1'b0) begin
      n_err++;
      $display("FAIL glitch got count=%0d empty=%b ferr=%b exp 0 1 0", count_a, empty_a, ferr_a);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      n_vec++;
      if (done_a !== 1'b0) begin
        n_err++;
        $display("FAIL break_done got %b exp 0", done_a);
      end
    end
    idle(10);
    send_frame(8'h12, 1'b1, 1'b0);
    n_vec++;
    if (ferr_a !== 1'b1 || count_a !== 11'd1) begin
      n_err++;
      $display("FAIL frame_err got ferr=%b count=%0d exp 1 1", ferr_a, count_a);
    end
    pop_one();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0 && mq.size() > 0) pop_one();
    end
    while (mq.size() > 0) pop_one();
    pop_one();
  endtask

  task automatic test_midframe_reset();
    send_frame(8'h9A, 1'b1, 1'b0);
    pop_one();
    send_frame(8'h77, 1'b1, 1'b0);
    set_rxd(1'b0);
    repeat (30) tick();
    #3 rst = 1'b1;
    rxd_a = 1'b1;
    #1;
    n_vec++;
    if (count_a !== 11'd0 || empty_a !== 1'b1 || rd_data_a !== 8'h00 || ferr_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset got count=%0d empty=%b rd=%02h ferr=%b ovf=%b exp 0 1 00 0 0",
               count_a, empty_a, rd_data_a, ferr_a, ovf_a);
    end
    repeat (2) tick();
    rst = 1'b0;
    mq.delete();
    exp_ferr = 1'b0; exp_ovf = 1'b0; exp_last = 8'h00;
    idle(100);
    send_frame(8'hC3, 1'b1, 1'b0);
    pop_one();
  endtask

  task automatic test_overflow();
    apply_reset(1'b1);
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, 1'b0);
      if (v == 4) begin
        n_vec++;
        if (full_b !== 1'b1 || ovf_b !== 1'b0) begin
          n_err++;
          $display("FAIL full_after4 got full=%b ovf=%b exp 1 0", full_b, ovf_b);
        end
      end
    end
    n_vec++;
    if (ovf_b !== 1'b1 || count_b !== 3'd4) begin
      n_err++;
      $display("FAIL overflow_after5 got ovf=%b count=%0d exp 1 4", ovf_b, count_b);
    end
    repeat (4) pop_one();
    pop_one();
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] first;
    apply_reset(1'b1);
    send_frame(8'hE1, 1'b1, 1'b1);
    first = 8'hE1;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_frame(8'h5E, 1'b1, 1'b1);
    n_vec++;
    if (rd_data_b !== first || full_b !== 1'b1 || ovf_b !== 1'b0 || count_b !== 3'd4) begin
      n_err++;
      $display("FAIL full_push_pop got rd=%02h full=%b ovf=%b count=%0d exp %02h 1 0 4",
               rd_data_b, full_b, ovf_b, count_b, first);
    end
    while (mq.size() > 0) pop_one();
  endtask

`ifdef RECV_IDLE_TIMEOUT_EN
  task automatic test_idle_timeout();
    apply_reset(1'b0);
    idle(200);
    n_vec++;
    if (tmo_a !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_no_byte got %b exp 0", tmo_a);
    end
    send_frame(8'h6B, 1'b1, 1'b0);
    idle(150);
    n_vec++;
    if (tmo_a !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early got %b exp 0", tmo_a);
    end
    idle(20);
    n_vec++;
    if (tmo_a !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_set got %b exp 1", tmo_a);
    end
    send_frame(8'h2D, 1'b1, 1'b0);
    n_vec++;
    if (tmo_a !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear got %b exp 0", tmo_a);
    end
    while (mq.size() > 0) pop_one();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random();
    test_midframe_reset();
    test_overflow();
    test_simul_push_pop();
`ifdef RECV_IDLE_TIMEOUT_EN
    test_idle_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/recv_contest_out.md
Name: recv_contest_out

Overview:
- UART receiver and capture buffer at the output end of the contest testbench link (8N1, LSB first, idle high).
- Monitors the core's serial txd line and deframes each byte.
- Pushes good bytes into an internal FIFO that the bench drains and compares against expected output.
- Reports framing errors and buffer overflow as sticky flags.

Parameters:
- CLK_PER_HALF_BIT, 435, clocks per half bit period; 435 gives 115200 bit/s.
- DEPTH_LOG2, 10, log2 of the FIFO depth in bytes.
- TIMEOUT_BITS, 20, idle bit periods before timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rxd  in  1  serial input, asynchronous to clk.
- rd_en  in  1  pop request; ignored when empty.
- rd_data  out  8  popped byte; registered, holds until the next pop.
- empty  out  1  FIFO has no entries.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  FIFO occupancy.
- byte_done  out  1  one-cycle pulse when a byte is accepted into the FIFO.
- frame_err  out  1  sticky: a stop bit sampled low.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.

Behaviour:
- Reset values: rd_data=0, empty=1, full=0, count=0, byte_done=0, frame_err=0, overflow=0. Internally: state=IDLE, synchronizer flops=1.
- Reset is asynchronous. Asserting rst mid-frame or mid-read aborts everything: the FIFO empties and sticky flags clear.
- rxd passes through a 2-flop synchronizer to give rxd_s. All decisions use rxd_s.
- Bit timer: counts 0..2*CLK_PER_HALF_BIT-1 and clears on every state change.
- IDLE: when rxd_s==0, go to START.
- START: at count CLK_PER_HALF_BIT-1 (mid start bit), sample rxd_s.
  - If 0: go to DATA with bit index 0.
  - If 1: treat as a glitch and return to IDLE; nothing is recorded.
- DATA: each time the count reaches 2*CLK_PER_HALF_BIT-1 (mid bit), shift rxd_s into the MSB of an 8-bit shift register (shift right).
  - After bit index 7, go to STOP.
- STOP: after one full bit period, sample rxd_s.
  - If 1 and FIFO not full: push the byte, pulse byte_done the next cycle, go to IDLE.
  - If 1 and FIFO full: drop the byte, set overflow, go to IDLE.
  - If 0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A held-low line never produces bytes.
- Latency: empty deasserts and count increments on the cycle after the stop-bit sample.
- FIFO: circular, DEPTH_LOG2-bit pointers that wrap modulo depth; count is the occupancy.
- Pop: when rd_en=1 and empty=0, rd_data updates on the next edge with the oldest byte.
  - rd_en while empty is ignored; rd_data holds and no flag is set.
- Simultaneous push and pop:
  - If full=1, the pop frees the slot, the push is accepted, count is unchanged and overflow is not set.
  - If empty=1, only the push occurs.
- full = (count == 2^DEPTH_LOG2). empty = (count == 0).
- Sticky flags clear only on rst.

Optional Feature:
- Macro RECV_IDLE_TIMEOUT_EN.
- Defined: adds output idle_timeout (1 bit, reset 0).
  - Its counter restarts whenever state leaves IDLE.
  - idle_timeout sets once at least one byte has been accepted and the line stays idle for TIMEOUT_BITS*2*CLK_PER_HALF_BIT clocks.
  - It clears when the next start bit is confirmed. The bench uses it to detect end of output.
- Undefined: no port, no counter; behaviour otherwise identical.

Test Plan:
- All scenarios use CLK_PER_HALF_BIT=4 (8-clock bit). DEPTH_LOG2=10 except the overflow scenario.
- Send 0x55, stop=1 -> byte_done pulse one cycle after stop sample; count=1; rd_en -> rd_data=0x55, empty=1.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap, then three pops -> rd_data sequence 0x00, 0xFF, 0xA5; frame_err=0.
- rxd low for 2 clocks, then high -> no byte, count=0, state returns to IDLE.
- Send 0x3C with stop bit 0, hold rxd low 40 clocks, release, then send 0x12 -> frame_err=1, only 0x12 in the FIFO (count=1).
- DEPTH_LOG2=2, send 5 bytes 0x01..0x05 with no reads -> full=1 after 4th byte, overflow=1 after 5th; pops return 0x01..0x04.
- With RECV_IDLE_TIMEOUT_EN and TIMEOUT_BITS=20: after the last byte, line idle 160 clocks -> idle_timeout=1; a new start bit clears it.
